// File: rtl/ahb_slave_ctrl.sv
// AHB-Lite byte-register slave: address/data-phase control, programmable wait
// states, two-cycle ERROR response and sticky error status.
module ahb_slave_ctrl #(
  parameter int unsigned WAIT_STATES = 1
) (
  input  logic       hclk,
  input  logic       hreset_n,
  input  logic       hsel_x,
  input  logic [7:0] haddr,
  input  logic [1:0] htrans,
  input  logic       hwrite,
  input  logic [2:0] hsize,
  input  logic [7:0] hwdata,
  input  logic       hready,
  output logic       hreadyout,
  output logic       hresp,
  output logic [1:0] read_select,
  output logic [1:0] err_status,
  output logic [7:0] payload_0,
  output logic [7:0] payload_1,
  output logic [4:0] data_size
);

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_WAIT,
    ST_LAST,
    ST_ERR1,
    ST_ERR2
  } state_t;

  localparam logic [2:0] WAIT_LOAD = (WAIT_STATES > 0) ? 3'(WAIT_STATES - 1) : 3'd0;

  state_t     state, state_nxt;
  logic [2:0] wcnt;
  logic       write_q;
  logic       accept_window;
  logic       sample;
  logic       size_err;
  logic       addr_err;
  logic       flagged;
  logic       clr_err;
  logic [1:0] set_err;

  assign accept_window = (state == ST_IDLE) || (state == ST_LAST) || (state == ST_ERR2);
  assign sample        = accept_window && hsel_x && hready && htrans[1];
  assign size_err      = (hsize != 3'b000);
  assign addr_err      = (haddr[7:2] != 6'd0) || (hwrite && (haddr[1:0] == 2'b00));
  assign flagged       = size_err || addr_err;

  // Flags are raised on the edge entering ERR1; the read-clear fires on the edge
  // ending LAST, so a back-to-back errored transfer can coincide and must win.
  assign clr_err = (state == ST_LAST) && !write_q && (read_select == 2'b00);
  assign set_err = (sample && flagged) ? {addr_err, size_err} : 2'b00;

  always_comb begin
    state_nxt = state;
    hreadyout = 1'b1;
    hresp     = 1'b0;
    case (state)
      ST_IDLE, ST_LAST, ST_ERR2: begin
        hresp = (state == ST_ERR2);
        if (sample) begin
          if (flagged)              state_nxt = ST_ERR1;
          else if (WAIT_STATES > 0) state_nxt = ST_WAIT;
          else                      state_nxt = ST_LAST;
        end else begin
          state_nxt = ST_IDLE;
        end
      end
      ST_WAIT: begin
        hreadyout = 1'b0;
        if (wcnt == 3'd0) state_nxt = ST_LAST;
      end
      ST_ERR1: begin
        hreadyout = 1'b0;
        hresp     = 1'b1;
        state_nxt = ST_ERR2;
      end
      default: state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge hclk or negedge hreset_n) begin
    if (!hreset_n) begin
      state       <= ST_IDLE;
      wcnt        <= '0;
      write_q     <= 1'b0;
      read_select <= '0;
      err_status  <= '0;
      payload_0   <= '0;
      payload_1   <= '0;
      data_size   <= '0;
    end else begin
      state <= state_nxt;

      if (sample) begin
        read_select <= haddr[1:0];
        write_q     <= hwrite;
        if (!flagged) wcnt <= WAIT_LOAD;
      end else if ((state == ST_WAIT) && (wcnt != 3'd0)) begin
        wcnt <= wcnt - 3'd1;
      end

      if ((state == ST_LAST) && write_q) begin
        case (read_select)
          2'd1:    payload_0 <= hwdata;
          2'd2:    payload_1 <= hwdata;
          2'd3:    data_size <= hwdata[4:0];
          default: ;
        endcase
      end

      err_status <= (clr_err ? 2'b00 : err_status) | set_err;
    end
  end

endmodule

// File: tb/tb_ahb_slave_ctrl.sv
// Directed bench for ahb_slave_ctrl: one instance with one wait state, one with
// none; transfer responses are checked against a scoreboard queue.
module tb_ahb_slave_ctrl;

  logic       hclk = 1'b0;
  logic       hreset_n;
  logic       hsel_a, hsel_b;
  logic [7:0] haddr;
  logic [1:0] htrans;
  logic       hwrite;
  logic [2:0] hsize;
  logic [7:0] hwdata;

  logic       hreadyout_a, hresp_a, hreadyout_b, hresp_b;
  logic [1:0] read_select_a, err_status_a, read_select_b, err_status_b;
  logic [7:0] payload_0_a, payload_1_a, payload_0_b, payload_1_b;
  logic [4:0] data_size_a, data_size_b;

  int unsigned vec = 0;
  int unsigned mis = 0;

  typedef struct {
    logic [1:0]  idx;
    logic        resp;
    int unsigned waits;
  } exp_t;
  exp_t sb[$];

  always #5 hclk = ~hclk;

  ahb_slave_ctrl #(.WAIT_STATES(1)) dut_a (
    .hclk(hclk), .hreset_n(hreset_n), .hsel_x(hsel_a), .haddr(haddr),
    .htrans(htrans), .hwrite(hwrite), .hsize(hsize), .hwdata(hwdata),
    .hready(hreadyout_a), .hreadyout(hreadyout_a), .hresp(hresp_a),
    .read_select(read_select_a), .err_status(err_status_a),
    .payload_0(payload_0_a), .payload_1(payload_1_a), .data_size(data_size_a)
  );

  ahb_slave_ctrl #(.WAIT_STATES(0)) dut_b (
    .hclk(hclk), .hreset_n(hreset_n), .hsel_x(hsel_b), .haddr(haddr),
    .htrans(htrans), .hwrite(hwrite), .hsize(hsize), .hwdata(hwdata),
    .hready(hreadyout_b), .hreadyout(hreadyout_b), .hresp(hresp_b),
    .read_select(read_select_b), .err_status(err_status_b),
    .payload_0(payload_0_b), .payload_1(payload_1_b), .data_size(data_size_b)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vec++;
    assert (obs === exp) else begin
      mis++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Full transfer on dut_a; returns at the negedge of the completing data-phase cycle.
  task automatic xfer_a(input logic [7:0] addr, input logic wr, input logic [2:0] size,
                        input logic [7:0] wd, input logic resp, input int unsigned waits);
    exp_t        e;
    int unsigned low;
    logic        first_resp, fin_resp, done;
    logic [1:0]  rs;
    @(posedge hclk); #1;
    hsel_a = 1'b1; haddr = addr; htrans = 2'b10; hwrite = wr; hsize = size;
    e.idx = addr[1:0]; e.resp = resp; e.waits = waits;
    sb.push_back(e);
    @(posedge hclk); #1;
    hsel_a = 1'b0; htrans = 2'b00; hwdata = wd;
    low = 0; done = 1'b0; first_resp = 1'b0; fin_resp = 1'b0; rs = 2'b00;
    for (int c = 0; c < 16 && !done; c++) begin
      @(negedge hclk);
      if (c == 0) rs = read_select_a;
      if (hreadyout_a) begin
        done = 1'b1;
        fin_resp = hresp_a;
      end else begin
        if (low == 0) first_resp = hresp_a;
        low++;
      end
    end
    e = sb.pop_front();
    chk("xfer_done", 32'(done), 32'd1);
    chk("xfer_waits", low, e.waits);
    chk("xfer_final_resp", 32'(fin_resp), 32'(e.resp));
    if (low > 0) chk("xfer_wait_resp", 32'(first_resp), 32'(e.resp));
    chk("xfer_read_select", 32'(rs), 32'(e.idx));
  endtask

  task automatic settle();
    @(posedge hclk); #1;
  endtask

  initial begin
    hreset_n = 1'b0; hsel_a = 1'b0; hsel_b = 1'b0; haddr = '0; htrans = '0;
    hwrite = 1'b0; hsize = '0; hwdata = '0;
    #1;
    chk("rst_ready_a", 32'(hreadyout_a), 32'd1);
    chk("rst_resp_a", 32'(hresp_a), 32'd0);
    chk("rst_rdsel_a", 32'(read_select_a), 32'd0);
    chk("rst_err_a", 32'(err_status_a), 32'd0);
    chk("rst_regs_a", {11'd0, data_size_a, payload_1_a, payload_0_a}, 32'd0);
    chk("rst_ready_b", 32'(hreadyout_b), 32'd1);
    chk("rst_regs_b", {11'd0, data_size_b, payload_1_b, payload_0_b}, 32'd0);
    #21 hreset_n = 1'b1;

    // BUSY with select, then NONSEQ without select: both ignored
    settle();
    hsel_a = 1'b1; haddr = 8'h01; htrans = 2'b01; hwrite = 1'b1; hwdata = 8'hEE;
    @(negedge hclk);
    chk("busy_ready", {hreadyout_a, hresp_a}, 32'b10);
    settle();
    hsel_a = 1'b0; htrans = 2'b10;
    @(negedge hclk);
    chk("nosel_ready", {hreadyout_a, hresp_a}, 32'b10);
    settle();
    htrans = 2'b00;
    @(negedge hclk);
    chk("ignored_state", {payload_0_a, 6'd0, read_select_a}, 32'd0);

    // Single-wait OKAY write; register updates only on the edge ending LAST
    xfer_a(8'h01, 1'b1, 3'b000, 8'hA5, 1'b0, 1);
    chk("p0_before_edge", 32'(payload_0_a), 32'h00);
    settle();
    chk("p0_written", 32'(payload_0_a), 32'hA5);

    // Size error on read, then status read clears it after LAST
    xfer_a(8'h02, 1'b0, 3'b001, 8'h00, 1'b1, 1);
    settle();
    chk("err_size", 32'(err_status_a), 32'b01);
    xfer_a(8'h00, 1'b0, 3'b000, 8'h00, 1'b0, 1);
    chk("err_held_in_last", 32'(err_status_a), 32'b01);
    settle();
    chk("err_cleared", 32'(err_status_a), 32'b00);

    // Write to read-only status register
    xfer_a(8'h00, 1'b1, 3'b000, 8'h5A, 1'b1, 1);
    settle();
    chk("err_ro", 32'(err_status_a), 32'b10);
    chk("ro_no_update", {11'd0, data_size_a, payload_1_a, payload_0_a}, {11'd0, 5'd0, 8'h00, 8'hA5});

    // data_size keeps only hwdata[4:0]; payload_1 write
    xfer_a(8'h03, 1'b1, 3'b000, 8'hEF, 1'b0, 1);
    settle();
    chk("dsize_trunc", 32'(data_size_a), 32'h0F);
    xfer_a(8'h02, 1'b1, 3'b000, 8'h66, 1'b0, 1);
    settle();
    chk("p1_written", 32'(payload_1_a), 32'h66);
    xfer_a(8'h01, 1'b1, 3'b010, 8'h11, 1'b1, 1);
    settle();
    chk("err_sticky", 32'(err_status_a), 32'b11);
    chk("size_err_no_update", 32'(payload_0_a), 32'hA5);

    // Status read followed back-to-back by an address-error write: set beats clear
    hsel_a = 1'b1; haddr = 8'h00; htrans = 2'b10; hwrite = 1'b0; hsize = 3'b000;
    settle();
    hsel_a = 1'b0; htrans = 2'b00;
    @(negedge hclk);
    chk("b2b_wait", 32'(hreadyout_a), 32'd0);
    settle();
    hsel_a = 1'b1; haddr = 8'h40; htrans = 2'b10; hwrite = 1'b1;
    @(negedge hclk);
    chk("b2b_last", {hreadyout_a, hresp_a, err_status_a}, {28'd0, 4'b1011});
    settle();
    hsel_a = 1'b0; htrans = 2'b00; hwdata = 8'h99;
    @(negedge hclk);
    chk("b2b_err1", {hreadyout_a, hresp_a}, 32'b01);
    settle();
    @(negedge hclk);
    chk("b2b_err2", {hreadyout_a, hresp_a}, 32'b11);
    settle();
    chk("set_wins", 32'(err_status_a), 32'b10);

    // Zero-wait slave: back-to-back writes never stall
    hsel_b = 1'b1; haddr = 8'h03; htrans = 2'b10; hwrite = 1'b1; hsize = 3'b000;
    @(negedge hclk);
    chk("b_ready0", 32'(hreadyout_b), 32'd1);
    settle();
    haddr = 8'h02; hwdata = 8'h1F;
    @(negedge hclk);
    chk("b_ready1", {hreadyout_b, hresp_b, read_select_b}, {28'd0, 4'b1011});
    settle();
    hsel_b = 1'b0; htrans = 2'b00; hwdata = 8'h3C;
    @(negedge hclk);
    chk("b_ready2", {hreadyout_b, hresp_b, read_select_b}, {28'd0, 4'b1010});
    chk("b_dsize", 32'(data_size_b), 32'h1F);
    settle();
    chk("b_p1", 32'(payload_1_b), 32'h3C);
    chk("b_ready3", 32'(hreadyout_b), 32'd1);

    // Reset during WAIT aborts the write
    hsel_a = 1'b1; haddr = 8'h01; htrans = 2'b10; hwrite = 1'b1; hsize = 3'b000;
    settle();
    hsel_a = 1'b0; htrans = 2'b00; hwdata = 8'h77;
    @(negedge hclk);
    chk("rst_mid_wait", 32'(hreadyout_a), 32'd0);
    #2 hreset_n = 1'b0;
    #1;
    chk("rst_mid_ready", {hreadyout_a, hresp_a}, 32'b10);
    chk("rst_mid_p0", 32'(payload_0_a), 32'h00);
    #1 hreset_n = 1'b1;
    settle();
    chk("rst_no_write", 32'(payload_0_a), 32'h00);
    xfer_a(8'h01, 1'b1, 3'b000, 8'h3C, 1'b0, 1);
    settle();
    chk("post_rst_write", 32'(payload_0_a), 32'h3C);

    $display("== %0d vectors applied, %0d miscompares ==", vec, mis);
    $finish;
  end

endmodule

// File: doc/ahb_slave_ctrl.md
AHB_SLAVE_CTRL -- requirements
Module: ahb_slave_ctrl

Interface
REQ-001 SHALL have parameter WAIT_STATES, default 1, number of wait cycles inserted per OKAY transfer (range 0-7).
REQ-002 SHALL have port hclk  input  1  bus clock; all state updates on its rising edge.
REQ-003 SHALL have port hreset_n  input  1  reset, asynchronous, active-low.
REQ-004 SHALL have port hsel_x  input  1  slave select from the address decoder.
REQ-005 SHALL have port haddr  input  8  byte address; bits [1:0] select the register, bits [7:2] must be zero.
REQ-006 SHALL have port htrans  input  2  transfer type (00 IDLE, 01 BUSY, 10 NONSEQ, 11 SEQ).
REQ-007 SHALL have port hwrite  input  1  1 = write, 0 = read.
REQ-008 SHALL have port hsize  input  3  transfer size; only 000 (byte) is legal.
REQ-009 SHALL have port hwdata  input  8  write data, valid in the data phase.
REQ-010 SHALL have port hready  input  1  bus-level ready (previous transfer complete).
REQ-011 SHALL have port hreadyout  output  1  this slave's ready.
REQ-012 SHALL have port hresp  output  1  0 = OKAY, 1 = ERROR.
REQ-013 SHALL have port read_select  output  2  registered register index for the downstream read stage.
REQ-014 SHALL have port err_status  output  2  sticky error flags; [0] = size error, [1] = address or read-only error.
REQ-015 SHALL have port payload_0, payload_1  output  8 each  read/write payload registers.
REQ-016 SHALL have port data_size  output  5  read/write length register.

Function
REQ-017 SHALL sample the address phase when hsel_x=1, hready=1 and htrans[1]=1; it SHALL capture haddr[1:0], hwrite and an error flag.
REQ-018 SHALL ignore IDLE and BUSY transfers, and transfers with hsel_x=0; these SHALL produce no state change and leave hreadyout=1, hresp=0.
REQ-019 SHALL flag an error when:
 - hsize!=000 (sets err_status[0]);
 - haddr[7:2]!=0 (sets err_status[1]);
 - a write targets index 0, the read-only status register (sets err_status[1]).
 Flags are set on the ERR1 cycle.
REQ-020 SHALL implement FSM states IDLE, WAIT, LAST, ERR1, ERR2.
REQ-021 From IDLE or LAST, a sampled transfer SHALL move to ERR1 if flagged, else to WAIT if WAIT_STATES>0, else to LAST; no sampled transfer SHALL return to IDLE.
REQ-022 WAIT SHALL hold hreadyout=0 for exactly WAIT_STATES cycles using a 3-bit down-counter, then go to LAST.
REQ-023 LAST SHALL drive hreadyout=1 and hresp=0; an OKAY transfer SHALL complete in exactly WAIT_STATES+1 data-phase cycles.
REQ-024 ERR1 SHALL drive hreadyout=0 and hresp=1; ERR2 SHALL drive hreadyout=1 and hresp=1; ERR2 SHALL behave as LAST for sampling a new address phase.
REQ-025 An OKAY write SHALL update the target register from hwdata in the LAST cycle:
 - index 1 -> payload_0;
 - index 2 -> payload_1;
 - index 3 -> data_size = hwdata[4:0].
 Errored writes SHALL update no register.
REQ-026 read_select SHALL equal the captured index from the cycle after address sampling until the next sample.
REQ-027 An OKAY read of index 0 SHALL clear err_status to 00 on the clock edge ending LAST, after the read stage has sampled it.
REQ-028 If a flag-set event and a clear occur on the same edge, the set SHALL win.
REQ-029 Back-to-back transfers: an address phase presented during LAST or ERR2 SHALL be accepted with no idle cycle.

Reset
REQ-030 On hreset_n=0 the block SHALL asynchronously go to IDLE with:
 - hreadyout=1, hresp=0;
 - read_select=00, err_status=00;
 - payload_0=00, payload_1=00, data_size=00;
 - wait counter=0.
REQ-031 Reset asserted mid-transfer SHALL abort the transfer with no register update; after release, the first valid address phase SHALL be accepted.

Verification
REQ-032 WAIT_STATES=1, write 0xA5 to addr 0x01 -> hreadyout low 1 cycle, then high with hresp=0; payload_0=0xA5 on the following edge.
REQ-033 Write to addr 0x00 -> ERR1 (hreadyout=0, hresp=1), then ERR2 (hreadyout=1, hresp=1); err_status=10; no register changes.
REQ-034 Read addr 0x02 with hsize=001 -> two-cycle error response and err_status=01; then read addr 0x00 -> OKAY, read_select=00, err_status=00 after LAST.
REQ-035 WAIT_STATES=0, back-to-back writes 0x1F to addr 0x03 then 0x3C to addr 0x02 -> hreadyout constantly 1; data_size=0x1F, payload_1=0x3C.
REQ-036 hreset_n pulsed low during WAIT of a write to addr 0x01 -> payload_0 stays 0x00, hreadyout=1 immediately; the next transfer completes normally.
